// File: rtl/banked_wram_ctrl.sv
// Banked working-RAM controller: WRAM array, bank-select IO register, valid/ready access port.
// Define BANKED_WRAM_CLEAR_EN to fill the array with CLEAR_VALUE after every reset.
module banked_wram_ctrl #(
  parameter int unsigned NUM_BANKS     = 8,
  parameter logic [15:0] BANK_REG_ADDR = 16'hFF70,
  parameter logic [7:0]  CLEAR_VALUE   = 8'h00
) (
  input  logic        I_CLK,
  input  logic        I_RESET_L,
  input  logic        I_IN_DMG_MODE,
  input  logic [15:0] I_IOREG_ADDR,
  input  logic [7:0]  I_IOREG_WDATA,
  input  logic        I_IOREG_WE_L,
  input  logic        I_IOREG_RE_L,
  output logic [7:0]  O_IOREG_RDATA,
  output logic        O_IOREG_DRIVE,
  input  logic        I_REQ,
  input  logic        I_WE,
  input  logic [15:0] I_ADDR,
  input  logic [7:0]  I_WDATA,
  output logic        O_READY,
  output logic [7:0]  O_RDATA,
  output logic        O_RVALID
);

  localparam int unsigned BSEL_W = $clog2(NUM_BANKS);
  localparam int unsigned ADDR_W = BSEL_W + 12;
  localparam int unsigned DEPTH  = NUM_BANKS * 4096;
  localparam logic [7:0]  FILL   = 8'hFF << BSEL_W;

`ifdef BANKED_WRAM_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
`else
  typedef enum logic {ST_RUN} state_t;
`endif

  logic [7:0]        mem [DEPTH];
  logic [BSEL_W-1:0] bank_field;
  logic [BSEL_W-1:0] eff_bank;
  logic [BSEL_W-1:0] sel_bank;
  logic              reg_hit;
  logic              mapped;
  logic              accept;
  logic [ADDR_W-1:0] phys_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  state_t            state;
  state_t            state_nxt;
  logic              unused_wdata;

  assign unused_wdata = ^I_IOREG_WDATA[7:BSEL_W];
  assign reg_hit      = (I_IOREG_ADDR == BANK_REG_ADDR);

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      bank_field <= '0;
    end else if (!I_IOREG_WE_L && reg_hit && !I_IN_DMG_MODE) begin
      bank_field <= I_IOREG_WDATA[BSEL_W-1:0];
    end
  end

  assign O_IOREG_DRIVE = !I_IOREG_RE_L && reg_hit;
  assign O_IOREG_RDATA = O_IOREG_DRIVE ? (FILL | 8'(bank_field)) : 8'hFF;

  always_comb begin
    if (I_IN_DMG_MODE || bank_field == '0) eff_bank = BSEL_W'(1'b1);
    else                                   eff_bank = bank_field;
  end

  // 0xC/0xE always hit bank 0; 0xD and the echo below 0xFE00 follow the switchable bank
  always_comb begin
    mapped   = 1'b1;
    sel_bank = eff_bank;
    case (I_ADDR[15:12])
      4'hC, 4'hE: sel_bank = '0;
      4'hD:       sel_bank = eff_bank;
      4'hF:       mapped   = (I_ADDR < 16'hFE00);
      default:    mapped   = 1'b0;
    endcase
  end

  assign phys_addr = {sel_bank, I_ADDR[11:0]};
  assign accept    = I_REQ && O_READY;

`ifdef BANKED_WRAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L)             clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end
`endif

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
`ifdef BANKED_WRAM_CLEAR_EN
      state <= ST_CLEAR;
`else
      state <= ST_RUN;
`endif
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef BANKED_WRAM_CLEAR_EN
    if (state == ST_CLEAR && clr_cnt == '1) state_nxt = ST_RUN;
`endif
  end

  always_comb begin
    O_READY = (state == ST_RUN);
  end

  // Clear engine and CPU writes share the single array write port
  always_comb begin
    mem_we    = accept && I_WE && mapped;
    mem_addr  = phys_addr;
    mem_wdata = mem_we ? I_WDATA : CLEAR_VALUE;
`ifdef BANKED_WRAM_CLEAR_EN
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = CLEAR_VALUE;
    end
`endif
  end

  always_ff @(posedge I_CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      O_RVALID <= 1'b0;
      O_RDATA  <= 8'h00;
    end else begin
      O_RVALID <= accept && !I_WE;
      if (accept && !I_WE) O_RDATA <= mapped ? mem[phys_addr] : 8'hFF;
    end
  end

endmodule

// File: tb/tb_banked_wram_ctrl.sv
// Self-checking bench for banked_wram_ctrl: directed vector table, randomized traffic vs a
// behavioural memory model, and reset/clear sequences (clear checks under BANKED_WRAM_CLEAR_EN).
module tb_banked_wram_ctrl;

  localparam int unsigned NB   = 8;
  localparam int unsigned BSEL = 3;
  localparam logic [15:0] REG  = 16'hFF70;
  localparam logic [7:0]  CLRV = 8'h00;
`ifdef BANKED_WRAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    bit          io_we;
    bit          io_re;
    logic [15:0] io_addr;
    logic [7:0]  io_wdata;
    bit          dmg;
    bit          req;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          exp_rvalid;
    bit          chk;
    logic [7:0]  exp_rdata;
    logic [7:0]  exp_io;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmg;
  logic [15:0] io_addr;
  logic [7:0]  io_wdata;
  logic        io_we_l;
  logic        io_re_l;
  logic [7:0]  io_rdata;
  logic        io_drive;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  rdata;
  logic        rvalid;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_mem   [NB*4096];
  bit         m_known [NB*4096];
  int         m_field;

  always #5 clk = ~clk;

  banked_wram_ctrl #(
    .NUM_BANKS(NB),
    .BANK_REG_ADDR(REG),
    .CLEAR_VALUE(CLRV)
  ) dut (
    .I_CLK(clk),
    .I_RESET_L(rst_n),
    .I_IN_DMG_MODE(dmg),
    .I_IOREG_ADDR(io_addr),
    .I_IOREG_WDATA(io_wdata),
    .I_IOREG_WE_L(io_we_l),
    .I_IOREG_RE_L(io_re_l),
    .O_IOREG_RDATA(io_rdata),
    .O_IOREG_DRIVE(io_drive),
    .I_REQ(req),
    .I_WE(we),
    .I_ADDR(addr),
    .I_WDATA(wdata),
    .O_READY(ready),
    .O_RDATA(rdata),
    .O_RVALID(rvalid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit iw, bit ir, logic [15:0] ia, logic [7:0] id, bit d,
                              bit rq, bit w, logic [15:0] a, logic [7:0] wd,
                              bit erv, bit c, logic [7:0] erd, logic [7:0] eio);
    vec_t v;
    v.io_we = iw; v.io_re = ir; v.io_addr = ia; v.io_wdata = id; v.dmg = d;
    v.req = rq; v.we = w; v.addr = a; v.wdata = wd;
    v.exp_rvalid = erv; v.chk = c; v.exp_rdata = erd; v.exp_io = eio;
    return v;
  endfunction

  task automatic model_reset_mem();
    for (int i = 0; i < NB*4096; i++) begin
      m_mem[i]   = CLRV;
      m_known[i] = CLR;
    end
  endtask

  // Reference: bank selection and byte storage evaluated directly from the address map rules
  task automatic model_step(input vec_t v, output bit erv, output bit ek,
                            output logic [7:0] erd, output logic [7:0] eio);
    int region, bank, idx;
    bit hit;
    region = int'(v.addr) / 4096;
    bank   = (v.dmg || m_field == 0) ? 1 : m_field;
    hit    = 1'b1;
    if (region == 12 || region == 14)                       bank = 0;
    else if (region == 13)                                  hit  = 1'b1;
    else if (region == 15 && int'(v.addr) < 'hFE00)        hit  = 1'b1;
    else                                                    hit  = 1'b0;
    idx = bank * 4096 + (int'(v.addr) % 4096);
    erv = v.req && !v.we;
    ek  = 1'b0;
    erd = 8'hFF;
    if (erv) begin
      if (hit) begin erd = m_mem[idx]; ek = m_known[idx]; end
      else     ek = 1'b1;
    end
    if (v.req && v.we && hit) begin
      m_mem[idx]   = v.wdata;
      m_known[idx] = 1'b1;
    end
    if (v.io_we && v.io_addr == REG && !v.dmg) m_field = int'(v.io_wdata) % NB;
    eio = (v.io_re && v.io_addr == REG) ? ((8'hFF << BSEL) | 8'(m_field)) : 8'hFF;
  endtask

  task automatic drive(input vec_t v);
    io_addr  = v.io_addr;
    io_wdata = v.io_wdata;
    io_we_l  = !v.io_we;
    io_re_l  = !v.io_re;
    dmg      = v.dmg;
    req      = v.req;
    we       = v.we;
    addr     = v.addr;
    wdata    = v.wdata;
  endtask

  task automatic apply(input vec_t v, input bit from_table, input string tag);
    bit erv, ek;
    logic [7:0] erd, eio;
    model_step(v, erv, ek, erd, eio);
    if (from_table) begin
      erv = v.exp_rvalid; ek = v.chk; erd = v.exp_rdata; eio = v.exp_io;
    end
    drive(v);
    @(posedge clk);
    #1;
    chk($sformatf("%s rvalid", tag), rvalid, erv);
    if (erv && ek) chk($sformatf("%s rdata", tag), rdata, erd);
    chk($sformatf("%s io_rdata", tag), io_rdata, eio);
    chk($sformatf("%s io_drive", tag), io_drive, v.io_re && v.io_addr == REG);
    chk($sformatf("%s ready", tag), ready, 1);
  endtask

  task automatic wait_ready(input string tag);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 40000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk(tag, cnt, CLR ? 32768 : 0);
  endtask

  vec_t idle;
  vec_t tbl[$];
  vec_t v;

  initial begin
    idle = mk(0,0,16'h0000,8'h00,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFF);
    rst_n = 1'b0;
    drive(idle);
    model_reset_mem();
    m_field = 0;
    repeat (3) @(posedge clk);
    #1;
    io_re_l = 1'b0;
    io_addr = REG;
    #1;
    chk("rst rvalid", rvalid, 0);
    chk("rst rdata", rdata, 8'h00);
    chk("rst io_rdata", io_rdata, 8'hF8);
    chk("rst ready", ready, CLR ? 0 : 1);
    drive(idle);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("clear_len");

`ifdef BANKED_WRAM_CLEAR_EN
    apply(mk(0,0,REG,0,0, 1,0,16'hC000,0, 0,0,0,0), 0, "clr C000");
    for (int b = 1; b < NB; b++) begin
      apply(mk(1,0,REG,8'(b),0, 0,0,0,0, 0,0,0,0), 0, $sformatf("clr sel%0d", b));
      apply(mk(0,0,REG,0,0, 1,0,16'hD7FF,0, 0,0,0,0), 0, $sformatf("clr D7FF b%0d", b));
    end
    apply(mk(1,0,REG,8'h00,0, 0,0,0,0, 0,0,0,0), 0, "clr sel0");
`endif

    // io_we io_re io_addr io_wdata dmg | req we addr wdata | exp_rvalid chk exp_rdata exp_io
    tbl.push_back(mk(1,0,REG,8'h04,1, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,1,REG,8'h00,1, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hF8));
    tbl.push_back(mk(0,0,REG,8'h00,1, 1,1,16'hD100,8'hC3, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(1,0,REG,8'h01,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,1,REG,8'h00,0, 1,0,16'hD100,8'h00, 1,1,8'hC3,8'hF9));
    tbl.push_back(mk(1,0,REG,8'h03,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,1,16'hD123,8'hA5, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(1,0,REG,8'h05,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,1,16'hD123,8'h3C, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hD123,8'h00, 1,1,8'h3C,8'hFF));
    tbl.push_back(mk(1,1,REG,8'h03,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFB));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hD123,8'h00, 1,1,8'hA5,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,1, 1,0,16'hD100,8'h00, 1,1,8'hC3,8'hFF));
    tbl.push_back(mk(1,0,REG,8'h00,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,1,16'hD010,8'h5A, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(1,0,REG,8'h01,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hD010,8'h00, 1,1,8'h5A,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,1,16'hC020,8'h11, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hE020,8'h00, 1,1,8'h11,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hFE00,8'h00, 1,1,8'hFF,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,1,16'hC000,8'h77, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hC000,8'h00, 1,1,8'h77,8'hFF));
    tbl.push_back(mk(1,0,REG,8'h02,0, 1,1,16'hD050,8'h99, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(1,0,REG,8'h01,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hD050,8'h00, 1,1,8'h99,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,1,16'hFE10,8'h12, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,1,16'hF200,8'h44, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hD200,8'h00, 1,1,8'h44,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hC000,8'h00, 1,1,8'h77,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hD010,8'h00, 1,1,8'h5A,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hE020,8'h00, 1,1,8'h11,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 1,0,16'hFF80,8'h00, 1,1,8'hFF,8'hFF));
    tbl.push_back(mk(0,0,REG,8'h00,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,1,16'hFF71,8'h00,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(1,0,16'hFF71,8'h05,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hFF));
    tbl.push_back(mk(0,1,REG,8'h00,0, 0,0,16'h0000,8'h00, 0,0,8'h00,8'hF9));
    foreach (tbl[i]) apply(tbl[i], 1, $sformatf("vec%0d", i));

    for (int n = 0; n < 600; n++) begin
      logic [3:0]  hi;
      logic [11:0] lo;
      case ($urandom_range(0, 4))
        0:       hi = 4'hC;
        1:       hi = 4'hD;
        2:       hi = 4'hE;
        3:       hi = 4'hF;
        default: hi = 4'hA;
      endcase
      lo = 12'($urandom_range(0, 7));
      v = idle;
      v.addr = (hi == 4'hF && $urandom_range(0, 2) == 0) ? (16'hFE00 | 16'(lo)) : {hi, lo};
      v.req      = ($urandom_range(0, 3) != 0);
      v.we       = $urandom_range(0, 1) == 1;
      v.wdata    = 8'($urandom);
      v.io_we    = ($urandom_range(0, 4) == 0);
      v.io_re    = $urandom_range(0, 1) == 1;
      v.io_addr  = ($urandom_range(0, 3) == 0) ? 16'hFF71 : REG;
      v.io_wdata = 8'($urandom);
      v.dmg      = ($urandom_range(0, 7) == 0);
      apply(v, 0, $sformatf("rnd%0d", n));
    end

    v = mk(0,0,REG,0,0, 1,0,16'hC000,0, 0,0,0,0);
    drive(v);
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst rvalid", rvalid, 0);
    chk("midrst rdata", rdata, 8'h00);
    drive(idle);
    io_re_l = 1'b0;
    io_addr = REG;
    #1;
    chk("midrst io_rdata", io_rdata, 8'hF8);
    drive(idle);
    m_field = 0;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef BANKED_WRAM_CLEAR_EN
    repeat (1000) @(posedge clk);
    #1;
    chk("midclear ready", ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset_mem();
`endif
    wait_ready("restart_len");
    apply(mk(0,1,REG,0,0, 1,0,16'hC000,0, 0,0,0,0), 0, "post C000");
    apply(mk(0,1,REG,0,0, 1,0,16'hD010,0, 0,0,0,0), 0, "post D010");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
